ysyx_23060075_lsu: RTL and testbench



---
 rtl/ysyx_23060075_lsu.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_23060075_lsu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060075_lsu.sv
// Sequential load/store unit.
// Accepts one memory op per req handshake and issues one width-aligned bus
// request with byte strobes. It then waits for the bus response, extends the
// load data and returns the result and an error code on a valid/ready
// response channel.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_*               op request from execute (valid/ready, load/store, funct3, addr, wdata)
//   resp_*              result channel (valid/ready, rdata, err: 00 ok/01 misaligned/10 bus/11 illegal)
//   mem_req_*, mem_*    bus request (valid/ready, aligned addr, wen, lane-shifted wdata, wstrb)
//   mem_resp_*          bus response (valid/ready, rdata, err)
module ysyx_23060075_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_load,
  input  logic                    req_store,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp_err
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e          state_q;
  logic            is_load_q;
  logic [2:0]      funct3_q;
  logic [OFF_W-1:0] offset_q;

  // Decode of the incoming request.
  logic [OFF_W-1:0]      req_off;
  logic                  legal;
  logic                  misaligned;
  logic [1:0]            dec_err;
  logic [STRB_WIDTH-1:0] size_mask;
  logic [DATA_WIDTH-1:0] wdata_masked;

  always_comb begin
    req_off = req_addr[OFF_W-1:0];
    legal   = 1'b0;
    if (req_load && !req_store) begin
      unique case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (DATA_WIDTH == 64);
        default:                                legal = 1'b0;
      endcase
    end else if (req_store && !req_load) begin
      unique case (req_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (DATA_WIDTH == 64);
        default:                legal = 1'b0;
      endcase
    end

    unique case (req_funct3[1:0])
      2'd0: begin misaligned = 1'b0;            size_mask = STRB_WIDTH'(8'h01); end
      2'd1: begin misaligned = req_addr[0];     size_mask = STRB_WIDTH'(8'h03); end
      2'd2: begin misaligned = |req_addr[1:0];  size_mask = STRB_WIDTH'(8'h0F); end
      default: begin misaligned = |req_addr[2:0]; size_mask = STRB_WIDTH'(8'hFF); end
    endcase

    // Illegal ops take priority over misalignment.
    dec_err = !legal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);

    wdata_masked = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      wdata_masked[i] = req_wdata[i] & size_mask[i/8];
    end
  end

  // Load data extraction from the registered op and the live bus data.
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  int unsigned           nbits;
  logic                  sign;

  always_comb begin
    shifted = mem_rdata >> {offset_q, 3'b000};
    unique case (funct3_q[1:0])
      2'd0:    nbits = 8;
      2'd1:    nbits = 16;
      2'd2:    nbits = 32;
      default: nbits = 64;
    endcase
    sign = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i == nbits - 1) sign = shifted[i];
    end
    load_data = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      // funct3[2] selects zero extension.
      load_data[i] = (i < nbits) ? shifted[i] : (!funct3_q[2] & sign);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      is_load_q      <= 1'b0;
      funct3_q       <= 3'b000;
      offset_q       <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 2'b00;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      mem_resp_ready <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            is_load_q <= req_load;
            funct3_q  <= req_funct3;
            offset_q  <= req_off;
            req_ready <= 1'b0;
            if (dec_err != 2'b00) begin
              // Rejected without touching the bus.
              resp_err   <= dec_err;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end else begin
              mem_addr      <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              mem_wen       <= req_store;
              mem_wstrb     <= size_mask << req_off;
              mem_wdata     <= req_store ? (wdata_masked << {req_off, 3'b000}) : '0;
              mem_req_valid <= 1'b1;
              state_q       <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state_q        <= StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            mem_resp_ready <= 1'b0;
            resp_valid     <= 1'b1;
            if (mem_resp_err) begin
              resp_err   <= 2'b10;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 2'b00;
              resp_rdata <= is_load_q ? load_data : '0;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060075_lsu.sv
module tb_ysyx_23060075_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; each DUT has its own req_valid so only one is active.
  logic        rst_n, req_load, req_store, resp_ready;
  logic        mem_req_ready, mem_resp_valid, mem_resp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic        a_req_valid, b_req_valid;

  logic        a_req_ready, a_resp_valid, a_mem_req_valid, a_mem_wen, a_mem_resp_ready;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_resp_err;
  logic [3:0]  a_mem_wstrb;
  logic        b_req_ready, b_resp_valid, b_mem_req_valid, b_mem_wen, b_mem_resp_ready;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [1:0]  b_resp_err;
  logic [7:0]  b_mem_wstrb;

  ysyx_23060075_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(a_mem_addr),
    .mem_wen(a_mem_wen), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(a_mem_resp_ready),
    .mem_rdata(mem_rdata[31:0]), .mem_resp_err(mem_resp_err)
  );

  ysyx_23060075_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(b_mem_addr),
    .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(b_mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  // Observation mux: sel=0 looks at the 32-bit DUT, sel=1 at the 64-bit DUT.
  bit          sel;
  logic        o_req_ready, o_resp_valid, o_mem_req_valid, o_mem_wen, o_mem_resp_ready;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [1:0]  o_err;
  logic [7:0]  o_strb;

  always_comb begin
    if (sel) begin
      o_req_ready = b_req_ready;   o_resp_valid = b_resp_valid;
      o_mem_req_valid = b_mem_req_valid; o_mem_wen = b_mem_wen;
      o_mem_resp_ready = b_mem_resp_ready;
      o_rdata = b_resp_rdata;      o_wdata = b_mem_wdata;
      o_addr = b_mem_addr;         o_err = b_resp_err;   o_strb = b_mem_wstrb;
    end else begin
      o_req_ready = a_req_ready;   o_resp_valid = a_resp_valid;
      o_mem_req_valid = a_mem_req_valid; o_mem_wen = a_mem_wen;
      o_mem_resp_ready = a_mem_resp_ready;
      o_rdata = {32'h0, a_resp_rdata}; o_wdata = {32'h0, a_mem_wdata};
      o_addr = a_mem_addr;         o_err = a_resp_err;   o_strb = {4'h0, a_mem_wstrb};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wdata);
    req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
  endtask

  // One op with a zero-wait bus; checks request lanes, latency and result.
  task automatic run_op(input string tag, input bit s, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata, input logic rerr,
                        input logic [1:0] exp_err, input logic [63:0] exp_rdata,
                        input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                        input int exp_cyc);
    int n;
    bit bus;
    sel = s;
    set_req(ld, st, f3, addr, wdata);
    mem_rdata = rdata; mem_resp_err = rerr;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    if (s) b_req_valid = 1'b1;
    else   a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    n = 1;
    bus = (exp_err == 2'b00) || (exp_err == 2'b10);
    check({tag, ".mem_req_valid"}, o_mem_req_valid, bus);
    if (bus) begin
      check({tag, ".mem_addr"}, o_addr, s ? (addr & 32'hFFFF_FFF8) : (addr & 32'hFFFF_FFFC));
      check({tag, ".wstrb"}, o_strb, exp_strb);
      check({tag, ".wen"}, o_mem_wen, st);
      if (st) check({tag, ".wdata"}, o_wdata, exp_wdata);
    end
    while (!o_resp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, exp_cyc);
    check({tag, ".err"}, o_err, exp_err);
    check({tag, ".rdata"}, o_rdata, exp_rdata);
    resp_ready = 1'b1;
    tick();
    check({tag, ".resp_done"}, o_resp_valid, 1'b0);
    check({tag, ".req_ready"}, o_req_ready, 1'b1);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0; resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = '0;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
    sel = 1'b0;
    tick(); tick();

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check("rst.req_ready", o_req_ready, 1'b1);
      check("rst.resp_valid", o_resp_valid, 1'b0);
      check("rst.mem_req_valid", o_mem_req_valid, 1'b0);
      check("rst.mem_resp_ready", o_mem_resp_ready, 1'b0);
      check("rst.wen", o_mem_wen, 1'b0);
      check("rst.wstrb", o_strb, 8'h00);
      check("rst.err", o_err, 2'b00);
      check("rst.rdata", o_rdata, 64'h0);
      check("rst.addr", o_addr, 32'h0);
      check("rst.wdata", o_wdata, 64'h0);
    end
    rst_n = 1'b1;
    tick();

    // 32-bit build
    run_op("sb", 0, 0, 1, 3'b000, 32'h8000_0003, 64'h1234_56AB, 64'h0, 0,
           2'b00, 64'h0, 8'h08, 64'hAB00_0000, 3);
    run_op("lh", 0, 1, 0, 3'b001, 32'h8000_0002, 64'h0, 64'hF00D_0000, 0,
           2'b00, 64'hFFFF_F00D, 8'h0C, 64'h0, 3);
    run_op("lhu", 0, 1, 0, 3'b101, 32'h8000_0002, 64'h0, 64'hF00D_0000, 0,
           2'b00, 64'h0000_F00D, 8'h0C, 64'h0, 3);
    run_op("lb", 0, 1, 0, 3'b000, 32'h8000_0001, 64'h0, 64'h0000_8000, 0,
           2'b00, 64'hFFFF_FF80, 8'h02, 64'h0, 3);
    run_op("lbu", 0, 1, 0, 3'b100, 32'h8000_0003, 64'h0, 64'h7F00_0000, 0,
           2'b00, 64'h0000_007F, 8'h08, 64'h0, 3);
    run_op("lw", 0, 1, 0, 3'b010, 32'h8000_0004, 64'h0, 64'hCAFE_F00D, 0,
           2'b00, 64'hCAFE_F00D, 8'h0F, 64'h0, 3);
    run_op("sh", 0, 0, 1, 3'b001, 32'h8000_0002, 64'hFFFF_1234, 64'h0, 0,
           2'b00, 64'h0, 8'h0C, 64'h1234_0000, 3);
    run_op("lw_mis", 0, 1, 0, 3'b010, 32'h8000_0001, 64'h0, 64'h0, 0,
           2'b01, 64'h0, 8'h00, 64'h0, 1);
    run_op("sh_mis", 0, 0, 1, 3'b001, 32'h8000_0001, 64'h0, 64'h0, 0,
           2'b01, 64'h0, 8'h00, 64'h0, 1);
    run_op("ld32", 0, 1, 0, 3'b011, 32'h8000_0008, 64'h0, 64'h0, 0,
           2'b11, 64'h0, 8'h00, 64'h0, 1);
    run_op("sd32", 0, 0, 1, 3'b011, 32'h8000_0008, 64'h0, 64'h0, 0,
           2'b11, 64'h0, 8'h00, 64'h0, 1);
    run_op("lwu32", 0, 1, 0, 3'b110, 32'h8000_0004, 64'h0, 64'h0, 0,
           2'b11, 64'h0, 8'h00, 64'h0, 1);
    run_op("st_f4", 0, 0, 1, 3'b100, 32'h8000_0000, 64'h0, 64'h0, 0,
           2'b11, 64'h0, 8'h00, 64'h0, 1);
    run_op("ld_st", 0, 1, 1, 3'b010, 32'h8000_0000, 64'h0, 64'h0, 0,
           2'b11, 64'h0, 8'h00, 64'h0, 1);
    run_op("no_op", 0, 0, 0, 3'b010, 32'h8000_0000, 64'h0, 64'h0, 0,
           2'b11, 64'h0, 8'h00, 64'h0, 1);

    // Request stall, then a bus error on the response.
    sel = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    set_req(1'b0, 1'b1, 3'b010, 32'h8000_0010, 64'hDEAD_BEEF);
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall.mem_req_valid", o_mem_req_valid, 1'b1);
      check("stall.addr", o_addr, 32'h8000_0010);
      check("stall.wstrb", o_strb, 8'h0F);
      check("stall.wdata", o_wdata, 64'hDEAD_BEEF);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    check("stall.mem_resp_ready", o_mem_resp_ready, 1'b1);
    check("stall.mem_req_done", o_mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_rdata = 64'h5555_5555;
    tick();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("buserr.resp_valid", o_resp_valid, 1'b1);
      check("buserr.err", o_err, 2'b10);
      check("buserr.rdata", o_rdata, 64'h0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("buserr.req_ready", o_req_ready, 1'b1);
    resp_ready = 1'b0;

    // Response held while resp_ready stays low.
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h1357_9BDF;
    set_req(1'b1, 1'b0, 3'b010, 32'h8000_0020, 64'h0);
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("hold.resp_valid", o_resp_valid, 1'b1);
      check("hold.rdata", o_rdata, 64'h1357_9BDF);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("hold.done", o_resp_valid, 1'b0);
    resp_ready = 1'b0;

    // Reset while waiting for the bus response.
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    set_req(1'b1, 1'b0, 3'b010, 32'h8000_0000, 64'h0);
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    check("wait.mem_resp_ready", o_mem_resp_ready, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rstw.req_ready", o_req_ready, 1'b1);
    check("rstw.mem_resp_ready", o_mem_resp_ready, 1'b0);
    check("rstw.resp_valid", o_resp_valid, 1'b0);
    check("rstw.mem_req_valid", o_mem_req_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    run_op("sh_after_rst", 0, 0, 1, 3'b001, 32'h8000_0000, 64'h0000_BEEF, 64'h0, 0,
           2'b00, 64'h0, 8'h03, 64'h0000_BEEF, 3);

    // 64-bit build
    run_op("ld64", 1, 1, 0, 3'b011, 32'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
           2'b00, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 3);
    run_op("lwu64", 1, 1, 0, 3'b110, 32'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0,
           2'b00, 64'h0000_0000_8765_4321, 8'hF0, 64'h0, 3);
    run_op("lw64", 1, 1, 0, 3'b010, 32'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0,
           2'b00, 64'hFFFF_FFFF_8765_4321, 8'hF0, 64'h0, 3);
    run_op("lb64", 1, 1, 0, 3'b000, 32'h8000_0007, 64'h0, 64'h8000_0000_0000_0000, 0,
           2'b00, 64'hFFFF_FFFF_FFFF_FF80, 8'h80, 64'h0, 3);
    run_op("sb64", 1, 0, 1, 3'b000, 32'h8000_0005, 64'h0000_00AB, 64'h0, 0,
           2'b00, 64'h0, 8'h20, 64'h0000_AB00_0000_0000, 3);
    run_op("sd64", 1, 0, 1, 3'b011, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 0,
           2'b00, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 3);
    run_op("ld64_mis", 1, 1, 0, 3'b011, 32'h8000_0004, 64'h0, 64'h0, 0,
           2'b01, 64'h0, 8'h00, 64'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
